// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register (pipe_skid_reg).
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } pipe_state_t;

  localparam int PIPE_DEFAULT_WIDTH = 16;
  localparam int STALL_CNT_W        = 16;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the stage's stall counter.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional stall counter port stall_cnt is built when PIPE_STALL_CNT_EN is defined.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = PIPE_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output pipe_state_t      dbg_state
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready/out_valid depend only on the state register (and rst), never on out_ready.

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_acc, out_acc;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = !rst && (state_q != FULL);
  assign out_data  = main_q;
  assign dbg_state = state_q;

  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_acc) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (in_acc && out_acc) begin
          main_d = in_data;
        end else if (in_acc) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_acc) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_acc) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything, including a word accepted this cycle; storage keeps stale data.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  sat_counter #(
    .WIDTH(STALL_CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid & ~out_ready),
    .clr  (flush),
    .count(stall_cnt)
  );
`endif

endmodule
